rv32i_ctrl_alu_dmem: RTL and testbench

Single-cycle RV32I slice that combines three parts: the main/ALU control decoder, the 32-bit ALU and the word-addressed data memory.
- Takes the fetched instruction, the register-file read data and the sign-extended immediate.
- Produces control strobes, the ALU result, the memory read data and the branch select for the PC.
- Sits between register_file/sign_extend and the write-back mux.
- A testbench-side init port preloads data memory before execution.

---
 rtl/rv32i_ctrl_alu_dmem_pkg.sv | 60 ++++++
 rtl/rv32i_ctrl_alu_dmem_bram32.sv | 36 +++
 rtl/rv32i_ctrl_alu_dmem.sv | 166 ++++++++++++++++
 tb/tb_rv32i_ctrl_alu_dmem.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_ctrl_alu_dmem_pkg.sv
// Shared constants for the RV32I control/ALU/data-memory slice.
// Holds the opcodes, the ALU, write-back and immediate codes, and the func3-to-ALU mapping.
package rv32i_ctrl_alu_dmem_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        ALU_RESULTS = 2'b00,
        MEMORY_READ = 2'b01,
        PC_PLUS_4   = 2'b10
    } wb_src_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_e;

    // alt selects SUB for func3=000 and SRA for func3=101; callers decide when it applies.
    function automatic alu_op_e alu_op_from_func3(input logic [2:0] func3, input logic alt);
        alu_op_e op;
        case (func3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_ctrl_alu_dmem_bram32.sv
// Word-organised data memory: one synchronous write port, one combinational read port
// and a combinational debug port. Byte addresses, low two bits ignored.
module rv32i_ctrl_alu_dmem_bram32
    import rv32i_ctrl_alu_dmem_pkg::*;
#(
    parameter int DATA_WIDTH = rv32i_ctrl_alu_dmem_pkg::DATA_WIDTH,
    parameter int WORDS      = 256,
    parameter int AW         = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [AW-1:0]         w_addr_i,
    input  logic [DATA_WIDTH-1:0] w_dat_i,
    input  logic [AW-1:0]         r_addr_i,
    output logic [DATA_WIDTH-1:0] r_dat_o,
    input  logic [AW-1:0]         debug_addr_i,
    output logic [DATA_WIDTH-1:0] debug_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    // Contents survive reset; reset only suppresses the write strobe.
    always_ff @(posedge clk) begin
        if (rst && we_i) begin
            mem_q[w_addr_i[AW-1:2]] <= w_dat_i;
        end
    end

    assign r_dat_o      = mem_q[r_addr_i[AW-1:2]];
    assign debug_data_o = mem_q[debug_addr_i[AW-1:2]];

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{w_addr_i[1:0], r_addr_i[1:0], debug_addr_i[1:0]};

endmodule

// File: rtl/rv32i_ctrl_alu_dmem.sv
// Single-cycle RV32I slice: main/ALU control decoder, 32-bit ALU and data memory.
// Everything except the memory array is combinational; rst (active-low) gates control and load data.
module rv32i_ctrl_alu_dmem
    import rv32i_ctrl_alu_dmem_pkg::*;
#(
    parameter int DATA_WIDTH = rv32i_ctrl_alu_dmem_pkg::DATA_WIDTH,
    parameter int DMEM_WORDS = 256,
    parameter int DMEM_AW    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  init_done,
    input  logic [DMEM_AW-1:0]    init_w_addr,
    input  logic [DATA_WIDTH-1:0] init_w_dat,
    input  logic                  init_w_enb,
    input  logic [DMEM_AW-1:0]    debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data,
    output logic                  branch,
    output logic [2:0]            imm_src,
    output logic                  alu_src,
    output logic [3:0]            alu_ctrl,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_2_reg,
    output logic                  reg_write,
    output logic [1:0]            wrt_back_src,
    output logic [DATA_WIDTH-1:0] alu_results,
    output logic                  alu_zero,
    output logic [DATA_WIDTH-1:0] mem_rdata
);

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7_b5;

    assign opcode   = instr[6:0];
    assign func3    = instr[14:12];
    assign func7_b5 = instr[30];

    always_comb begin
        imm_src      = IMM_I;
        alu_src      = 1'b0;
        alu_ctrl     = ALU_ADD;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_2_reg    = 1'b0;
        reg_write    = 1'b0;
        wrt_back_src = ALU_RESULTS;
        if (rst) begin
            case (opcode)
                OPC_R: begin
                    reg_write = 1'b1;
                    alu_ctrl  = alu_op_from_func3(func3, func7_b5);
                end
                OPC_I_ALU: begin
                    // func7[5] only means something for shifts right; ADDI must never become SUB.
                    reg_write = 1'b1;
                    alu_src   = 1'b1;
                    alu_ctrl  = alu_op_from_func3(func3, (func3 == 3'b101) && func7_b5);
                end
                OPC_LOAD: begin
                    reg_write    = 1'b1;
                    alu_src      = 1'b1;
                    mem_read     = 1'b1;
                    mem_2_reg    = 1'b1;
                    wrt_back_src = MEMORY_READ;
                end
                OPC_STORE: begin
                    mem_write = 1'b1;
                    alu_src   = 1'b1;
                    imm_src   = IMM_S;
                end
                OPC_BRANCH: begin
                    alu_ctrl = ALU_SUB;
                    imm_src  = IMM_B;
                end
                OPC_JAL: begin
                    reg_write    = 1'b1;
                    wrt_back_src = PC_PLUS_4;
                    imm_src      = IMM_J;
                end
                default: ;
            endcase
        end
    end

    logic        [DATA_WIDTH-1:0] alu_b;
    logic signed [DATA_WIDTH-1:0] alu_a_s;
    logic signed [DATA_WIDTH-1:0] alu_b_s;
    logic        [4:0]            shamt;

    assign alu_b   = alu_src ? imm : rs2_data;
    assign alu_a_s = rs1_data;
    assign alu_b_s = alu_b;
    assign shamt   = alu_b[4:0];

    always_comb begin
        alu_results = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_results = rs1_data + alu_b;
            ALU_SUB:  alu_results = rs1_data - alu_b;
            ALU_AND:  alu_results = rs1_data & alu_b;
            ALU_OR:   alu_results = rs1_data | alu_b;
            ALU_XOR:  alu_results = rs1_data ^ alu_b;
            ALU_SLL:  alu_results = rs1_data << shamt;
            ALU_SRL:  alu_results = rs1_data >> shamt;
            ALU_SRA:  alu_results = alu_a_s >>> shamt;
            ALU_SLT:  alu_results = {{(DATA_WIDTH-1){1'b0}}, (alu_a_s < alu_b_s)};
            ALU_SLTU: alu_results = {{(DATA_WIDTH-1){1'b0}}, (rs1_data < alu_b)};
            default:  alu_results = '0;
        endcase
    end

    assign alu_zero = (alu_results == '0);

    // Kept apart from the decoder so alu_zero never loops back into the ALU-control block.
    always_comb begin
        branch = 1'b0;
        if (rst) begin
            if (opcode == OPC_JAL) begin
                branch = 1'b1;
            end else if (opcode == OPC_BRANCH) begin
                case (func3)
                    F3_BEQ:  branch = alu_zero;
                    F3_BNE:  branch = ~alu_zero;
                    default: branch = 1'b0;
                endcase
            end
        end
    end

    logic                  wr_en;
    logic [DMEM_AW-1:0]    wr_addr;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [DATA_WIDTH-1:0] rd_dat;

    assign wr_en   = init_done ? mem_write             : init_w_enb;
    assign wr_addr = init_done ? alu_results[DMEM_AW-1:0] : init_w_addr;
    assign wr_dat  = init_done ? rs2_data              : init_w_dat;

    rv32i_ctrl_alu_dmem_bram32 #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (DMEM_WORDS),
        .AW         (DMEM_AW)
    ) u_dmem (
        .clk          (clk),
        .rst          (rst),
        .we_i         (wr_en),
        .w_addr_i     (wr_addr),
        .w_dat_i      (wr_dat),
        .r_addr_i     (alu_results[DMEM_AW-1:0]),
        .r_dat_o      (rd_dat),
        .debug_addr_i (debug_addr),
        .debug_data_o (debug_data)
    );

    assign mem_rdata = (rst && mem_read) ? rd_dat : '0;

    logic unused_bits;
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7], alu_results[DATA_WIDTH-1:DMEM_AW]};

endmodule

// File: tb/tb_rv32i_ctrl_alu_dmem.sv
// Directed-vector bench for rv32i_ctrl_alu_dmem with hand-computed expectations.
module tb_rv32i_ctrl_alu_dmem;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        init_done;
    logic [9:0]  init_w_addr;
    logic [31:0] init_w_dat;
    logic        init_w_enb;
    logic [9:0]  debug_addr;
    logic [31:0] debug_data;
    logic        branch;
    logic [2:0]  imm_src;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic        mem_read;
    logic        mem_write;
    logic        mem_2_reg;
    logic        reg_write;
    logic [1:0]  wrt_back_src;
    logic [31:0] alu_results;
    logic        alu_zero;
    logic [31:0] mem_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    rv32i_ctrl_alu_dmem dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .init_done    (init_done),
        .init_w_addr  (init_w_addr),
        .init_w_dat   (init_w_dat),
        .init_w_enb   (init_w_enb),
        .debug_addr   (debug_addr),
        .debug_data   (debug_data),
        .branch       (branch),
        .imm_src      (imm_src),
        .alu_src      (alu_src),
        .alu_ctrl     (alu_ctrl),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_2_reg    (mem_2_reg),
        .reg_write    (reg_write),
        .wrt_back_src (wrt_back_src),
        .alu_results  (alu_results),
        .alu_zero     (alu_zero),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ctrl_obs;
    assign ctrl_obs = {17'b0, branch, imm_src, alu_src, alu_ctrl,
                       mem_read, mem_write, mem_2_reg, reg_write, wrt_back_src};

    function automatic logic [31:0] cv(input logic br, input logic [2:0] is, input logic as,
                                       input logic [3:0] ac, input logic mr, input logic mw,
                                       input logic m2r, input logic rw, input logic [1:0] wb);
        return {17'b0, br, is, as, ac, mr, mw, m2r, rw, wb};
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
        return {f7, 10'b0, f3, 5'b0, opc};
    endfunction

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] IA = 7'b0010011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] JL = 7'b1101111;
    localparam logic [6:0] F7A = 7'b0100000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im);
        instr    = ins;
        rs1_data = a;
        rs2_data = b;
        imm      = im;
        #1;
    endtask

    task automatic init_wr(input logic [9:0] addr, input logic [31:0] dat);
        init_w_addr = addr;
        init_w_dat  = dat;
        init_w_enb  = 1'b1;
        tick();
        init_w_enb  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; init_done = 1'b0; init_w_addr = '0; init_w_dat = '0; init_w_enb = 1'b0;
        debug_addr = '0;

        // reset: all control zero
        op(mk(7'd0, 3'b000, R), 32'd1, 32'd2, 32'd0);
        chk("rst_ctrl", ctrl_obs, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("add_ctrl", ctrl_obs, cv(0, 3'b000, 0, 4'b0000, 0, 0, 0, 1, 2'b00));
        chk("add_res", alu_results, 32'd3);
        chk("add_zero", {31'b0, alu_zero}, 32'd0);

        // preload memory via init port
        init_wr(10'h000, 32'h1);
        init_wr(10'h004, 32'h2);
        init_wr(10'h020, 32'h11);

        // reset blocks writes, gates load data, keeps contents
        rst = 1'b0;
        op(mk(7'd0, 3'b010, LD), 32'd0, 32'd0, 32'h20);
        init_w_addr = 10'h020; init_w_dat = 32'h99; init_w_enb = 1'b1;
        #1;
        chk("rst2_ctrl", ctrl_obs, 32'd0);
        chk("rst2_rdata", mem_rdata, 32'd0);
        tick();
        init_w_enb = 1'b0;
        rst = 1'b1;
        debug_addr = 10'h020;
        #1;
        chk("rst_keep", debug_data, 32'h11);

        // loads
        init_done = 1'b1;
        op(mk(7'd0, 3'b010, LD), 32'd0, 32'd0, 32'd4);
        chk("lw_ctrl", ctrl_obs, cv(0, 3'b000, 1, 4'b0000, 1, 0, 1, 1, 2'b01));
        chk("lw_addr", alu_results, 32'd4);
        chk("lw_data", mem_rdata, 32'h2);
        op(mk(7'd0, 3'b010, LD), 32'd0, 32'd0, 32'd1);
        chk("lw_lsb", mem_rdata, 32'h1);
        op(mk(7'd0, 3'b010, LD), 32'd0, 32'd0, 32'h404);
        chk("lw_alias", mem_rdata, 32'h2);

        // SUB
        op(mk(F7A, 3'b000, R), 32'd5, 32'd3, 32'd0);
        chk("sub_ctrl", ctrl_obs, cv(0, 3'b000, 0, 4'b0001, 0, 0, 0, 1, 2'b00));
        chk("sub_res", alu_results, 32'd2);

        // store
        op(mk(7'd0, 3'b010, ST), 32'd0, 32'd3, 32'hC);
        chk("sw_ctrl", ctrl_obs, cv(0, 3'b001, 1, 4'b0000, 0, 1, 0, 0, 2'b00));
        chk("sw_rdata", mem_rdata, 32'd0);
        tick();
        op(32'd0, 32'd0, 32'd0, 32'd0);
        chk("nop_ctrl", ctrl_obs, 32'd0);
        debug_addr = 10'h00C;
        #1;
        chk("sw_mem", debug_data, 32'h3);

        // same-word write/read: old value before the edge, new value after
        init_done = 1'b0;
        op(mk(7'd0, 3'b010, LD), 32'd0, 32'd0, 32'd0);
        init_w_addr = 10'h000; init_w_dat = 32'h77; init_w_enb = 1'b1;
        #1;
        chk("rw_old", mem_rdata, 32'h1);
        tick();
        init_w_enb = 1'b0;
        #1;
        chk("rw_new", mem_rdata, 32'h77);
        init_done = 1'b1;

        // branches and jump
        op(mk(7'd0, 3'b000, BR), 32'd7, 32'd7, 32'd0);
        chk("beq_ctrl", ctrl_obs, cv(1, 3'b010, 0, 4'b0001, 0, 0, 0, 0, 2'b00));
        chk("beq_zero", {31'b0, alu_zero}, 32'd1);
        op(mk(7'd0, 3'b001, BR), 32'd7, 32'd7, 32'd0);
        chk("bne_eq", {31'b0, branch}, 32'd0);
        op(mk(7'd0, 3'b000, BR), 32'd7, 32'd8, 32'd0);
        chk("beq_ne", {31'b0, branch}, 32'd0);
        op(mk(7'd0, 3'b001, BR), 32'd7, 32'd8, 32'd0);
        chk("bne_ne", {31'b0, branch}, 32'd1);
        op(mk(7'd0, 3'b100, BR), 32'd7, 32'd8, 32'd0);
        chk("blt_none", {31'b0, branch}, 32'd0);
        op(mk(7'd0, 3'b000, JL), 32'd0, 32'd0, 32'd0);
        chk("jal_ctrl", ctrl_obs, cv(1, 3'b100, 0, 4'b0000, 0, 0, 0, 1, 2'b10));

        // ALU corners
        op(mk(F7A, 3'b101, R), 32'h8000_0000, 32'd4, 32'd0);
        chk("sra_ctrl", ctrl_obs, cv(0, 3'b000, 0, 4'b0111, 0, 0, 0, 1, 2'b00));
        chk("sra_res", alu_results, 32'hF800_0000);
        op(mk(F7A, 3'b101, IA), 32'h8000_0000, 32'd0, 32'h404);
        chk("srai_res", alu_results, 32'hF800_0000);
        op(mk(7'd0, 3'b101, IA), 32'h8000_0000, 32'd0, 32'd4);
        chk("srli_res", alu_results, 32'h0800_0000);
        op(mk(F7A, 3'b000, IA), 32'd10, 32'd0, 32'd5);
        chk("addi_ctrl", ctrl_obs, cv(0, 3'b000, 1, 4'b0000, 0, 0, 0, 1, 2'b00));
        chk("addi_res", alu_results, 32'd15);
        op(mk(7'd0, 3'b010, R), 32'hFFFF_FFFF, 32'd1, 32'd0);
        chk("slt_res", alu_results, 32'd1);
        op(mk(7'd0, 3'b011, R), 32'hFFFF_FFFF, 32'd1, 32'd0);
        chk("sltu_res", alu_results, 32'd0);
        op(mk(7'd0, 3'b000, R), 32'hFFFF_FFFF, 32'd1, 32'd0);
        chk("wrap_res", alu_results, 32'd0);
        chk("wrap_zero", {31'b0, alu_zero}, 32'd1);
        op(mk(7'd0, 3'b111, R), 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0);
        chk("and_res", alu_results, 32'h00F0_000F);
        op(mk(7'd0, 3'b110, R), 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0);
        chk("or_res", alu_results, 32'hFFF0_0FFF);
        op(mk(7'd0, 3'b100, R), 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0);
        chk("xor_res", alu_results, 32'hFF00_0FF0);
        op(mk(7'd0, 3'b001, R), 32'd1, 32'h3F, 32'd0);
        chk("sll_res", alu_results, 32'h8000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
